// File: rtl/hdmi_qsys_nios2_qsys_mult_seq_if.sv
// ---------------------------------------------------------------------------
// hdmi_qsys_nios2_qsys_mult_seq_if
//
// Bundles the request/response side of the sequential multiplier together
// with the operand/result wires of the external 32x16 multiply cell.
//
//   start             : request a multiply (sampled only while idle)
//   kill              : synchronous abort of an in-flight operation
//   src1, src2        : operands, captured when a start is accepted
//   busy              : operation in flight
//   done              : one-cycle completion pulse
//   result            : low DATA_W bits of src1*src2, held until next completion
//   A_mul_src1        : operand A presented to the multiply cell
//   A_mul_src2        : operand B presented to the multiply cell (upper half 0)
//   A_mul_cell_result : cell product, valid one clock after its operands
//
// Modports:
//   master : the requester plus the multiply cell (drives requests and the
//            cell product, observes status and cell operands)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface hdmi_qsys_nios2_qsys_mult_seq_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              kill;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] A_mul_src1;
  logic [DATA_W-1:0] A_mul_src2;
  logic [DATA_W-1:0] A_mul_cell_result;

  modport master (
    output start,
    output kill,
    output src1,
    output src2,
    output A_mul_cell_result,
    input  busy,
    input  done,
    input  result,
    input  A_mul_src1,
    input  A_mul_src2
  );

  modport slave (
    input  start,
    input  kill,
    input  src1,
    input  src2,
    input  A_mul_cell_result,
    output busy,
    output done,
    output result,
    output A_mul_src1,
    output A_mul_src2
  );
endinterface

// File: rtl/hdmi_qsys_nios2_qsys_mult_seq.sv
// ---------------------------------------------------------------------------
// hdmi_qsys_nios2_qsys_mult_seq
//
// Sequential DATA_W x DATA_W -> DATA_W (low half) multiplier built around an
// external DATA_W x DATA_W/2 multiply cell with one clock of latency.
//
// The product is formed from two half-width partial products:
//   P0 = a * b[lo]                  (cell operands presented in MUL_LO)
//   P1 = a * b[hi]                  (cell operands presented in MUL_HI)
//   result = P0 + (P1 << DATA_W/2)  mod 2^DATA_W
// Only the low half of P1 can reach the kept result bits, and the low bits
// of a product do not depend on operand signedness, so no sign handling is
// needed anywhere.
//
// Sequence (start accepted at edge N):
//   N   : IDLE   -> MUL_LO, operands latched
//   N+1 : MUL_LO -> MUL_HI
//   N+2 : MUL_HI -> ACCUM,  acc <= P0
//   N+3 : ACCUM  -> IDLE,   result <= acc + (P1 << DATA_W/2), done <= 1
// done is therefore high in the cycle after N+3, which is also an IDLE
// cycle, so a new start can be accepted there (one op every 4 cycles).
//
// kill in any non-idle state returns to IDLE at the next edge with no done
// and result untouched; kill also blocks a simultaneous start in IDLE.
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears all state and outputs
//   mbus    : request/response and multiply-cell signals (slave view)
// ---------------------------------------------------------------------------
module hdmi_qsys_nios2_qsys_mult_seq #(
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  hdmi_qsys_nios2_qsys_mult_seq_if.slave    mbus
);

  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_LO = 2'd1,
    MUL_HI = 2'd2,
    ACCUM  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Latched operands and the running partial sum.
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] acc;

  // Registered outputs.
  logic [DATA_W-1:0] result;
  logic              done;

  // Combinational control strobes from the FSM.
  logic              accept;
  logic              cap_p0;
  logic              finish;
  logic [DATA_W-1:0] cell_b;

  // Final combine: add the high partial product, shifted into the upper
  // half, to the low partial product. Bits shifted past DATA_W-1 and the
  // carry out of the top bit fall away, which is exactly the mod 2^DATA_W
  // behaviour wanted for the low half of the full product.
  function automatic logic [DATA_W-1:0] combine_hi(
    input logic [DATA_W-1:0] acc_in,
    input logic [DATA_W-1:0] p1
  );
    logic [DATA_W-1:0] p1_shifted;
    p1_shifted = p1 << HALF_W;
    return acc_in + p1_shifted;
  endfunction

  // ---- state register -----------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next state and cell operand selection ------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cap_p0    = 1'b0;
    finish    = 1'b0;
    cell_b    = '0;

    unique case (state)
      IDLE: begin
        // kill outranks start even though there is nothing to abort.
        if (mbus.start && !mbus.kill) begin
          accept    = 1'b1;
          state_nxt = MUL_LO;
        end
      end

      MUL_LO: begin
        cell_b    = {{HALF_W{1'b0}}, b[HALF_W-1:0]};
        state_nxt = mbus.kill ? IDLE : MUL_HI;
      end

      MUL_HI: begin
        // The cell now returns P0 for the operands shown in MUL_LO.
        cell_b = {{HALF_W{1'b0}}, b[DATA_W-1:HALF_W]};
        if (mbus.kill) begin
          state_nxt = IDLE;
        end else begin
          cap_p0    = 1'b1;
          state_nxt = ACCUM;
        end
      end

      ACCUM: begin
        // The cell now returns P1; a kill here suppresses the completion.
        finish    = !mbus.kill;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- operand latch, partial-sum and result registers --------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        a <= mbus.src1;
        b <= mbus.src2;
      end
      if (cap_p0) begin
        acc <= mbus.A_mul_cell_result;
      end
      if (finish) begin
        result <= combine_hi(acc, mbus.A_mul_cell_result);
      end
    end
  end

  // ---- outputs -------------------------------------------------------------
  // Operand A is simply the latched multiplicand in every state; it is zero
  // out of reset because a is cleared there.
  assign mbus.A_mul_src1 = a;
  assign mbus.A_mul_src2 = cell_b;
  assign mbus.busy       = (state != IDLE);
  assign mbus.done       = done;
  assign mbus.result     = result;

endmodule

// File: tb/tb_hdmi_qsys_nios2_qsys_mult_seq.sv
module tb_hdmi_qsys_nios2_qsys_mult_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hdmi_qsys_nios2_qsys_mult_seq_if #(.DATA_W(32)) mb ();

  hdmi_qsys_nios2_qsys_mult_seq #(.DATA_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mbus    (mb)
  );

  // Multiply cell: 32 x 16 product, low 32 bits, one clock of latency.
  logic [31:0] cell_q = 32'h0;
  always @(posedge clk) cell_q <= mb.A_mul_src1 * {16'h0, mb.A_mul_src2[15:0]};
  assign mb.A_mul_cell_result = cell_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] full;
    full = 64'(x) * 64'(y);
    return full[31:0];
  endfunction

  // Called at a falling edge in IDLE. Issues one op and checks every cycle
  // up to and including the done cycle; returns at the done-cycle negedge.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] exp;
    exp = ref_mul(x, y);
    mb.start = 1'b1;
    mb.src1  = x;
    mb.src2  = y;
    @(negedge clk);
    mb.start = 1'b0;
    mb.src1  = $urandom;
    mb.src2  = $urandom;
    chk({tag, "_busy0"}, 32'(mb.busy), 32'd1);
    chk({tag, "_done0"}, 32'(mb.done), 32'd0);
    chk({tag, "_opa"}, mb.A_mul_src1, x);
    chk({tag, "_oplo"}, mb.A_mul_src2, {16'h0, y[15:0]});
    @(negedge clk);
    chk({tag, "_done1"}, 32'(mb.done), 32'd0);
    chk({tag, "_ophi"}, mb.A_mul_src2, {16'h0, y[31:16]});
    @(negedge clk);
    chk({tag, "_busy2"}, 32'(mb.busy), 32'd1);
    chk({tag, "_opacc"}, mb.A_mul_src2, 32'h0);
    @(negedge clk);
    chk({tag, "_done3"}, 32'(mb.done), 32'd1);
    chk({tag, "_busy3"}, 32'(mb.busy), 32'd0);
    chk({tag, "_result"}, mb.result, exp);
  endtask

  initial begin
    mb.start = 1'b0;
    mb.kill  = 1'b0;
    mb.src1  = 32'hDEAD_BEEF;
    mb.src2  = 32'h1234_5678;

    // Reset state, with start held high meanwhile.
    mb.start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(mb.busy), 32'd0);
    chk("rst_done", 32'(mb.done), 32'd0);
    chk("rst_result", mb.result, 32'h0);
    chk("rst_opa", mb.A_mul_src1, 32'h0);
    chk("rst_opb", mb.A_mul_src2, 32'h0);
    mb.start = 1'b0;
    reset_n = 1'b1;

    // Directed products.
    run_op(32'h0001_0003, 32'h0002_0005, "small");
    chk("small_val", mb.result, 32'h000B_000F);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones");
    chk("ones_val", mb.result, 32'h0000_0001);
    run_op(32'hFFFF_FFFD, 32'h0000_0007, "neg");
    chk("neg_val", mb.result, 32'hFFFF_FFEB);

    // Result holds while idle.
    repeat (3) @(negedge clk);
    chk("hold_result", mb.result, 32'hFFFF_FFEB);
    chk("hold_done", 32'(mb.done), 32'd0);

    // start held high through an op: mid-op starts ignored, one extra op
    // accepted in the done cycle.
    mb.start = 1'b1; mb.src1 = 32'd2; mb.src2 = 32'd3;
    @(negedge clk);
    mb.src1 = 32'd100; mb.src2 = 32'd200;
    @(negedge clk);
    mb.src1 = 32'd11; mb.src2 = 32'd13;
    @(negedge clk);
    chk("b2b_mid_done", 32'(mb.done), 32'd0);
    @(negedge clk);
    chk("b2b_first_done", 32'(mb.done), 32'd1);
    chk("b2b_first_val", mb.result, 32'd6);
    mb.src1 = 32'd7; mb.src2 = 32'd9;
    @(negedge clk);
    mb.start = 1'b0;
    chk("b2b_pulse_width", 32'(mb.done), 32'd0);
    chk("b2b_second_busy", 32'(mb.busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("b2b_gap_done", 32'(mb.done), 32'd0);
    @(negedge clk);
    chk("b2b_second_done", 32'(mb.done), 32'd1);
    chk("b2b_second_val", mb.result, 32'd63);

    // Reset asserted in MUL_HI.
    mb.start = 1'b1; mb.src1 = 32'h55; mb.src2 = 32'h77;
    @(negedge clk);
    mb.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(mb.busy), 32'd0);
    chk("rstmid_done", 32'(mb.done), 32'd0);
    chk("rstmid_result", mb.result, 32'h0);
    chk("rstmid_opa", mb.A_mul_src1, 32'h0);
    chk("rstmid_opb", mb.A_mul_src2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstmid_no_done", 32'(mb.done), 32'd0);
    end

    // kill in ACCUM after a prior result of 0x1234.
    run_op(32'h0000_1234, 32'h0000_0001, "prior");
    mb.start = 1'b1; mb.src1 = 32'd5; mb.src2 = 32'd5;
    @(negedge clk);
    mb.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("killacc_busy", 32'(mb.busy), 32'd1);
    mb.kill = 1'b1;
    @(negedge clk);
    mb.kill = 1'b0;
    chk("killacc_done", 32'(mb.done), 32'd0);
    chk("killacc_result", mb.result, 32'h0000_1234);
    chk("killacc_busy_after", 32'(mb.busy), 32'd0);

    // kill together with start in IDLE: start not accepted.
    mb.start = 1'b1; mb.kill = 1'b1;
    @(negedge clk);
    mb.start = 1'b0; mb.kill = 1'b0;
    chk("killidle_busy", 32'(mb.busy), 32'd0);

    // kill in MUL_LO, then a normal op still works.
    mb.start = 1'b1; mb.src1 = 32'd9; mb.src2 = 32'd9;
    @(negedge clk);
    mb.start = 1'b0; mb.kill = 1'b1;
    @(negedge clk);
    mb.kill = 1'b0;
    chk("killlo_busy", 32'(mb.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("killlo_done", 32'(mb.done), 32'd0);
    chk("killlo_result", mb.result, 32'h0000_1234);
    run_op(32'h8000_0001, 32'h0001_0000, "after_kill");

    // Random back-to-back ops against the reference product.
    for (int i = 0; i < 10000; i++) begin
      run_op($urandom, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_qsys_nios2_qsys_mult_seq.md
HDMI_QSYS_NIOS2_QSYS_MULT_SEQ -- requirements
Module: HDMI_QSYS_nios2_qsys_mult_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: ports clk and reset_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  request a multiply; sampled only in IDLE.
REQ-005 kill  in  1  synchronous abort of an in-flight operation.
REQ-006 src1  in  32  multiplicand, latched on start accept.
REQ-007 src2  in  32  multiplier, latched on start accept.
REQ-008 busy  out  1  high whenever state != IDLE.
REQ-009 done  out  1  registered one-cycle completion pulse.
REQ-010 result  out  32  low 32 bits of src1*src2, registered.
REQ-011 A_mul_src1  out  32  operand A to the downstream multiply cell.
REQ-012 A_mul_src2  out  32  operand B to the multiply cell; upper 16 bits always 0.
REQ-013 A_mul_cell_result  in  32  cell output: (A_mul_src1 * A_mul_src2[15:0]) mod 2^32, valid one clock after its operands are presented.

Function
REQ-014 SHALL implement the states IDLE, MUL_LO, MUL_HI, ACCUM.
REQ-015 IDLE with start=1 at edge N: latch a=src1 and b=src2, then go to MUL_LO.
REQ-016 IDLE with start=0: stay in IDLE.
REQ-017 MUL_LO: drive A_mul_src1=a and A_mul_src2={16'h0,b[15:0]}, then go to MUL_HI.
REQ-018 MUL_HI: drive A_mul_src2={16'h0,b[31:16]} and capture P0=A_mul_cell_result into acc at the end of the cycle, then go to ACCUM.
REQ-019 ACCUM: with P1=A_mul_cell_result, set result<=(acc+{P1[15:0],16'h0}) mod 2^32 and done<=1, then go to IDLE.
REQ-020 Fixed latency: start accepted at edge N gives result valid and done=1 in the cycle after edge N+3.
REQ-021 done SHALL be high for exactly one cycle per completed operation.
REQ-022 result SHALL hold its value until the next completion or reset.
REQ-023 A_mul_src1 SHALL equal a in every state; A_mul_src2 SHALL be 0 in IDLE and ACCUM.
REQ-024 start while busy=1 SHALL be ignored: no latch, no queuing.
REQ-025 start in the cycle where done=1 (state already IDLE) SHALL be accepted, allowing back-to-back operations every 4 cycles.
REQ-026 kill=1 in any non-IDLE state: go to IDLE at the next edge with no done pulse and result unchanged.
REQ-027 kill has priority over ACCUM completion.
REQ-028 kill in IDLE has no effect; kill and start together in IDLE: kill wins, start is not accepted.
REQ-029 Arithmetic SHALL be sign-agnostic: the low 32 bits are identical for signed and unsigned operands, so no sign handling is done.
REQ-030 All arithmetic SHALL be mod 2^32 with carries out of bit 31 discarded.

Reset
REQ-031 reset_n=0 SHALL immediately force: state=IDLE, busy=0, done=0, result=0, a=0, b=0, acc=0, A_mul_src1=0, A_mul_src2=0.
REQ-032 Reset mid-operation SHALL abandon the operation with no done pulse, either during reset or after release.
REQ-033 After reset_n rises, the first start SHALL be accepted at the first rising edge where start=1.

Verification
REQ-034 src1=0x00010003, src2=0x00020005 -> done at N+3, result=0x000B000F.
REQ-035 src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result=0x00000001; src1=0xFFFFFFFD, src2=0x00000007 -> result=0xFFFFFFEB.
REQ-036 start at N with (2,3), start held high through N+3 -> only one extra op, accepted at the done cycle; results 6 then the second product, done pulses 4 cycles apart, and the mid-op starts are ignored.
REQ-037 reset_n=0 asserted while in MUL_HI -> busy=0, done=0, result=0 immediately; no done after release.
REQ-038 kill in ACCUM during op (5,5) after a prior result of 0x1234 -> no done, result stays 0x1234, busy=0 next cycle.
REQ-039 Random 10k ops against a reference model: result=(src1*src2)[31:0], and the cell is modelled with 1-cycle latency.
